ssd_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver for N hex digits, replacing the fixed 4-digit scan logic at top level. It holds a shadow copy of the digit values, which is loaded by a strobe so the display cannot tear mid-update. It adds per-digit enable, blink and decimal point control, and produces registered, glitch-free anode and cathode outputs. It sits between the Sudoku solver/top-level status signals and the board's An*/Ca..Cg/Dp pins.

---
 rtl/ssd_pkg.sv | 47 ++++
 rtl/ssd_hex_decoder.sv | 15 +
 rtl/ssd_scan_driver.sv | 134 +++++++++++++
 tb/tb_ssd_scan_driver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and helpers for the seven-segment scan driver.
//   SSD_HEX_SEG   : 16-entry hex-to-segment table, active-high, bit order {a,b,c,d,e,f,g}
//   ssd_clog2     : ceiling log2, used to size the digit index
//   ssd_seg_off / ssd_an_off / ssd_dp_off : inactive pin levels for a given polarity;
//     XOR with an active-high value yields the pin value.
package ssd_pkg;

   // Entry 0 is the least significant element.
   localparam logic [15:0][6:0] SSD_HEX_SEG = {
      7'b1000111,   // F
      7'b1001111,   // E
      7'b0111101,   // d
      7'b1001110,   // C
      7'b0011111,   // b
      7'b1110111,   // A
      7'b1111011,   // 9
      7'b1111111,   // 8
      7'b1110000,   // 7
      7'b1011111,   // 6
      7'b1011011,   // 5
      7'b0110011,   // 4
      7'b1111001,   // 3
      7'b1101101,   // 2
      7'b0110000,   // 1
      7'b1111110    // 0
   };

   function automatic int ssd_clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic logic [6:0] ssd_seg_off(input int active_low);
      return (active_low != 0) ? 7'h7F : 7'h00;
   endfunction

   function automatic logic [15:0] ssd_an_off(input int active_low);
      return (active_low != 0) ? 16'hFFFF : 16'h0000;
   endfunction

   function automatic logic ssd_dp_off(input int active_low);
      return (active_low != 0);
   endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: combinational hex digit to seven-segment pattern.
//   i_hex [3:0] : hex value
//   o_seg [6:0] : active-high segments {a,b,c,d,e,f,g}
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SSD_HEX_SEG[i_hex];
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed N-digit seven-segment display driver.
//   board_clk, Reset      : clock, async active-high reset
//   load                  : strobe capturing digits_in and all masks into the shadow
//   digits_in [4N-1:0]    : digit i at bits [4i+3:4i]
//   enable_mask/blink_mask/dp_mask [N-1:0] : per-digit show / blink / decimal point
//   an [N-1:0], seg [6:0] {a..g}, dp : registered pin drives
//   cur_digit             : index that produced the current pin values
//   scan_tick             : high in the last prescaler cycle of each dwell
// The shadow registers decouple the display from the producer so a
// multi-cycle update of digits_in never shows up half-applied.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int SCAN_DIV_BITS  = 18,
   parameter int BLINK_DIV_BITS = 25,
   parameter int ACTIVE_LOW     = 1,
   localparam int IDX_W         = ssd_clog2(NUM_DIGITS)
)(
   input  logic                    board_clk,
   input  logic                    Reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   enable_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [IDX_W-1:0]        cur_digit,
   output logic                    scan_tick
);

   localparam logic [6:0]            SEG_OFF = ssd_seg_off(ACTIVE_LOW);
   localparam logic [15:0]           AN_ALL  = ssd_an_off(ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ALL[NUM_DIGITS-1:0];
   localparam logic                  DP_OFF  = ssd_dp_off(ACTIVE_LOW);
   localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   logic [SCAN_DIV_BITS-1:0]       r_pre;
   logic [BLINK_DIV_BITS-1:0]      r_blink;
   logic [IDX_W-1:0]               r_idx;
   logic [NUM_DIGITS-1:0][3:0]     r_sh_digits;
   logic [NUM_DIGITS-1:0]          r_sh_en;
   logic [NUM_DIGITS-1:0]          r_sh_bl;
   logic [NUM_DIGITS-1:0]          r_sh_dp;
   logic [NUM_DIGITS-1:0]          r_an;
   logic [6:0]                     r_seg;
   logic                           r_dp;
   logic [IDX_W-1:0]               r_cur;

   logic                           w_tick;
   logic                           w_phase;
   logic                           w_vis;
   logic [3:0]                     w_digit;
   logic [6:0]                     w_dec;
   logic [NUM_DIGITS-1:0]          w_an_ah;
   logic [6:0]                     w_seg_ah;
   logic                           w_dp_ah;

   assign w_tick  = (r_pre == '1);
   assign w_phase = r_blink[BLINK_DIV_BITS-1];   // 1 = blinking digits hidden
   assign w_digit = r_sh_digits[r_idx];

   ssd_hex_decoder u_dec (
      .i_hex (w_digit),
      .o_seg (w_dec)
   );

   // Counters and digit index; the index only advances on the tick edge and
   // wraps explicitly so non-power-of-two digit counts work.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_pre   <= '0;
         r_blink <= '0;
         r_idx   <= '0;
      end else begin
         r_pre   <= r_pre + SCAN_DIV_BITS'(1);
         r_blink <= r_blink + BLINK_DIV_BITS'(1);
         if (w_tick)
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Shadow registers: independent of the scan, so a load on the tick edge
   // is simply seen by the new index one cycle later.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_sh_digits <= '0;
         r_sh_en     <= '0;
         r_sh_bl     <= '0;
         r_sh_dp     <= '0;
      end else if (load) begin
         r_sh_digits <= digits_in;
         r_sh_en     <= enable_mask;
         r_sh_bl     <= blink_mask;
         r_sh_dp     <= dp_mask;
      end
   end

   always_comb begin
      w_vis    = r_sh_en[r_idx] & ~(r_sh_bl[r_idx] & w_phase);
      w_an_ah  = '0;
      w_seg_ah = '0;
      w_dp_ah  = 1'b0;
      if (w_vis) begin
         w_an_ah  = NUM_DIGITS'(1) << r_idx;
         w_seg_ah = w_dec;
         w_dp_ah  = r_sh_dp[r_idx];
      end
   end

   // Output register: polarity applied by XOR with the inactive level.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         r_an  <= AN_OFF;
         r_seg <= SEG_OFF;
         r_dp  <= DP_OFF;
         r_cur <= '0;
      end else begin
         r_an  <= w_an_ah ^ AN_OFF;
         r_seg <= w_seg_ah ^ SEG_OFF;
         r_dp  <= w_dp_ah ^ DP_OFF;
         r_cur <= r_idx;
      end
   end

   assign an        = r_an;
   assign seg       = r_seg;
   assign dp        = r_dp;
   assign cur_digit = r_cur;
   assign scan_tick = w_tick;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Testbench for ssd_scan_driver with fast sim dividers (dwell 4, blink 32).
// Reference model: time since reset release k, shadow captured on load;
// pins after edge k reflect digit (k-1)/4 mod 8 and blink phase of (k-1) mod 32.
module tb_ssd_scan_driver;

   localparam int ND = 8;

   logic            board_clk = 1'b0;
   logic            Reset     = 1'b1;
   logic            load      = 1'b0;
   logic [4*ND-1:0] digits_in = '0;
   logic [ND-1:0]   enable_mask = '0;
   logic [ND-1:0]   blink_mask  = '0;
   logic [ND-1:0]   dp_mask     = '0;
   logic [ND-1:0]   an;
   logic [6:0]      seg;
   logic            dp;
   logic [2:0]      cur_digit;
   logic            scan_tick;

   int n_vec = 0;
   int n_bad = 0;

   // model state
   int              k;
   logic [4*ND-1:0] m_dig;
   logic [ND-1:0]   m_en, m_bl, m_dp;

   ssd_scan_driver #(
      .NUM_DIGITS(ND), .SCAN_DIV_BITS(2), .BLINK_DIV_BITS(5), .ACTIVE_LOW(1)
   ) dut (
      .board_clk(board_clk), .Reset(Reset), .load(load), .digits_in(digits_in),
      .enable_mask(enable_mask), .blink_mask(blink_mask), .dp_mask(dp_mask),
      .an(an), .seg(seg), .dp(dp), .cur_digit(cur_digit), .scan_tick(scan_tick)
   );

   always #5 board_clk = ~board_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", tag, got, exp, k, $time);
      end
   endtask

   function automatic logic [6:0] hexpat(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;  default: return 7'b1000111;
      endcase
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_an"},  32'(an),  32'hFF);
      chk({tag, "_seg"}, 32'(seg), 32'h7F);
      chk({tag, "_dp"},  32'(dp),  32'h1);
   endtask

   task automatic model_reset();
      k = 0; m_dig = '0; m_en = '0; m_bl = '0; m_dp = '0;
   endtask

   // One clock: drive inputs, advance model across the edge, check pins.
   task automatic step(input logic ld, input logic [4*ND-1:0] d,
                       input logic [ND-1:0] en, input logic [ND-1:0] bl, input logic [ND-1:0] dm);
      int kp, ix;
      logic vis, hid;
      logic [ND-1:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      load = ld; digits_in = d; enable_mask = en; blink_mask = bl; dp_mask = dm;
      @(posedge board_clk);
      kp  = k;
      ix  = (kp / 4) % ND;
      hid = (kp % 32) >= 16;
      vis = m_en[ix] && !(m_bl[ix] && hid);
      e_an  = vis ? ~(ND'(1) << ix) : '1;
      e_seg = vis ? ~hexpat(m_dig[4*ix +: 4]) : 7'h7F;
      e_dp  = !(vis && m_dp[ix]);
      if (ld) begin m_dig = d; m_en = en; m_bl = bl; m_dp = dm; end
      k++;
      #1;
      chk("an",   32'(an),   32'(e_an));
      chk("seg",  32'(seg),  32'(e_seg));
      chk("dp",   32'(dp),   32'(e_dp));
      chk("cur",  32'(cur_digit), 32'(ix));
      chk("tick", 32'(scan_tick), 32'((k % 4) == 3));
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
   endtask

   initial begin
      model_reset();
      // reset state while held
      repeat (2) @(posedge board_clk);
      #1;
      check_idle("rst");
      chk("rst_cur",  32'(cur_digit), 32'h0);
      chk("rst_tick", 32'(scan_tick), 32'h0);
      @(negedge board_clk); Reset = 1'b0;

      // 1: no load, dark, index cycles and wraps
      idle(40);
      // 2: digits 0..7, all enabled
      step(1'b1, 32'h76543210, 8'hFF, 8'h00, 8'h00);
      idle(40);
      // 3: upper half disabled, dp on some digits
      step(1'b1, 32'hFEDCBA98, 8'h0F, 8'h00, 8'h5A);
      idle(40);
      // 4: digit 0 blinks
      step(1'b1, 32'h89ABCDEF, 8'hFF, 8'h01, 8'h81);
      idle(70);
      // 5: load on the tick edge, new value for the incoming digit
      while ((k % 4) != 3) idle(1);
      step(1'b1, 32'h0000C000 | 32'(((k / 4 + 1) % ND) << 8), 8'hFF, 8'h00, 8'hFF);
      idle(8);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0)
            step(1'b1, $urandom, ND'($urandom), ND'($urandom), ND'($urandom));
         else
            step(1'b0, $urandom, ND'($urandom), ND'($urandom), ND'($urandom));
      end
      // 6: reset mid-dwell on digit 5, with a fully lit pattern loaded
      step(1'b1, 32'h88888888, 8'hFF, 8'h00, 8'hFF);
      while (!(((k - 1) / 4) % ND == 5 && (k % 4) == 2)) idle(1);
      chk("pre_rst_lit", 32'(an), 32'hDF);
      #2 Reset = 1'b1;
      #1;
      check_idle("async_rst");
      chk("async_cur", 32'(cur_digit), 32'h0);
      @(negedge board_clk); Reset = 1'b0;
      model_reset();
      idle(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
